// File: rtl/fetch_unit.sv
// Instruction fetch and operand-address stage feeding the decoder.
// mem_addr_o/mem_rd_o are registered; read data is expected on mem_data_i while they are presented.
module fetch_unit #(
  parameter int unsigned           REG_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_o,
  input  logic [REG_WIDTH-1:0]  mem_data_i,
  input  logic [REG_WIDTH-1:0]  x_in_i,
  input  logic [REG_WIDTH-1:0]  y_in_i,
  output logic [REG_WIDTH-1:0]  instruction_out_o,
  output logic [REG_WIDTH-1:0]  imm_out_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  instruction_ready_o,
  input  logic                  instruction_done_i,
  input  logic                  pc_load_i,
  input  logic [ADDR_WIDTH-1:0] pc_in_i,
  output logic [ADDR_WIDTH-1:0] pc_out_o
);

  typedef enum logic [2:0] {
    StFetch,
    StWaitOp,
    StOpl,
    StOph,
    StPtrl,
    StPtrh,
    StReady
  } state_e;

  localparam logic [2:0] ModeXInd = 3'b000;
  localparam logic [2:0] ModeZpg  = 3'b001;
  localparam logic [2:0] ModeImm  = 3'b010;
  localparam logic [2:0] ModeAbs  = 3'b011;
  localparam logic [2:0] ModeIndY = 3'b100;
  localparam logic [2:0] ModeZpgX = 3'b101;
  localparam logic [2:0] ModeAbsY = 3'b110;
  localparam logic [2:0] ModeAbsX = 3'b111;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [REG_WIDTH-1:0]    opcode_q, opcode_d;
  logic [REG_WIDTH-1:0]    imm_q, imm_d;
  logic [REG_WIDTH-1:0]    ptr_lo_q, ptr_lo_d;
  logic [REG_WIDTH-1:0]    zp_hi_q, zp_hi_d;
  logic [REG_WIDTH-1:0]    idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic [2:0]              mode;
  logic [REG_WIDTH-1:0]    zp_ptr;
  logic [ADDR_WIDTH-1:0]   abs_base;

  assign mode = opcode_q[4:2];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    opcode_d   = opcode_q;
    imm_d      = imm_q;
    ptr_lo_d   = ptr_lo_q;
    zp_hi_d    = zp_hi_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    zp_ptr     = '0;
    abs_base   = ADDR_WIDTH'({mem_data_i, imm_q});

    unique case (state_q)
      StFetch: begin
        mem_addr_d = pc_q;
        mem_rd_d   = 1'b1;
        pc_d       = pc_q + ADDR_WIDTH'(1);
        state_d    = StWaitOp;
      end
      StWaitOp: begin
        opcode_d   = mem_data_i;
        mem_addr_d = pc_q;
        mem_rd_d   = 1'b1;
        pc_d       = pc_q + ADDR_WIDTH'(1);
        state_d    = StOpl;
      end
      StOpl: begin
        imm_d = mem_data_i;
        unique case (mode)
          ModeAbs, ModeAbsX, ModeAbsY: begin
            mem_addr_d = pc_q;
            mem_rd_d   = 1'b1;
            pc_d       = pc_q + ADDR_WIDTH'(1);
            state_d    = StOph;
          end
          ModeXInd, ModeIndY: begin
            // Pointer stays in zero page: the hi-byte address wraps within REG_WIDTH.
            zp_ptr     = (mode == ModeXInd) ? mem_data_i + x_in_i : mem_data_i;
            mem_addr_d = ADDR_WIDTH'(zp_ptr);
            mem_rd_d   = 1'b1;
            zp_hi_d    = zp_ptr + REG_WIDTH'(1);
            state_d    = StPtrl;
          end
          ModeImm: begin
            // mem_addr_q still holds the operand byte address here.
            addr_d  = mem_addr_q;
            state_d = StReady;
          end
          ModeZpg: begin
            addr_d  = ADDR_WIDTH'(mem_data_i);
            state_d = StReady;
          end
          ModeZpgX: begin
            zp_ptr  = mem_data_i + x_in_i;
            addr_d  = ADDR_WIDTH'(zp_ptr);
            state_d = StReady;
          end
          default: state_d = StFetch;
        endcase
      end
      StOph: begin
        if (mode == ModeAbsX) begin
          addr_d = abs_base + ADDR_WIDTH'(x_in_i);
        end else if (mode == ModeAbsY) begin
          addr_d = abs_base + ADDR_WIDTH'(y_in_i);
        end else begin
          addr_d = abs_base;
        end
        state_d = StReady;
      end
      StPtrl: begin
        ptr_lo_d   = mem_data_i;
        mem_addr_d = ADDR_WIDTH'(zp_hi_q);
        mem_rd_d   = 1'b1;
        idx_d      = (mode == ModeIndY) ? y_in_i : '0;
        state_d    = StPtrh;
      end
      StPtrh: begin
        addr_d  = ADDR_WIDTH'({mem_data_i, ptr_lo_q}) + ADDR_WIDTH'(idx_q);
        state_d = StReady;
      end
      StReady: begin
        if (instruction_done_i) begin
          if (pc_load_i) begin
            pc_d = pc_in_i;
          end
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      opcode_q   <= '0;
      imm_q      <= '0;
      ptr_lo_q   <= '0;
      zp_hi_q    <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      opcode_q   <= opcode_d;
      imm_q      <= imm_d;
      ptr_lo_q   <= ptr_lo_d;
      zp_hi_q    <= zp_hi_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
    end
  end

  assign mem_addr_o          = mem_addr_q;
  assign mem_rd_o            = mem_rd_q;
  assign instruction_out_o   = opcode_q;
  assign imm_out_o           = imm_q;
  assign addr_o              = addr_q;
  assign instruction_ready_o = (state_q == StReady);
  assign pc_out_o            = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: addressing modes, handshake, PC load and async reset.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic [7:0]  instruction_out;
  logic [7:0]  imm_out;
  logic [15:0] addr;
  logic        instruction_ready;
  logic        instruction_done;
  logic        pc_load;
  logic [15:0] pc_in;
  logic [15:0] pc_out;

  logic [7:0]  mem [0:65535];
  int          checks;
  int          failures;
  int          lat;

  assign mem_data = mem[mem_addr];

  fetch_unit #(
    .REG_WIDTH (8),
    .ADDR_WIDTH(16),
    .RESET_PC  (16'h0200)
  ) dut (
    .clk_i              (clk),
    .reset_ni           (reset_n),
    .mem_addr_o         (mem_addr),
    .mem_rd_o           (mem_rd),
    .mem_data_i         (mem_data),
    .x_in_i             (x_in),
    .y_in_i             (y_in),
    .instruction_out_o  (instruction_out),
    .imm_out_o          (imm_out),
    .addr_o             (addr),
    .instruction_ready_o(instruction_ready),
    .instruction_done_i (instruction_done),
    .pc_load_i          (pc_load),
    .pc_in_i            (pc_in),
    .pc_out_o           (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Counts rising edges until instruction_ready is seen; bounded at 20.
  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (instruction_ready) break;
    end
  endtask

  task automatic done_pulse();
    instruction_done = 1'b1;
    @(posedge clk);
    #1;
    instruction_done = 1'b0;
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset_n          = 1'b0;
    x_in             = 8'h00;
    y_in             = 8'h00;
    instruction_done = 1'b0;
    pc_load          = 1'b0;
    pc_in            = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;

    // Reset values
    hold_reset();
    check("rst_ready", instruction_ready, 0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_instr", instruction_out, 8'h00);
    check("rst_imm", imm_out, 8'h00);
    check("rst_addr", addr, 16'h0000);
    check("rst_pc", pc_out, 16'h0200);

    // IMM
    mem[16'h0200] = 8'hA9;
    mem[16'h0201] = 8'h42;
    release_reset();
    wait_ready(lat);
    check("imm_lat", lat, 3);
    check("imm_instr", instruction_out, 8'hA9);
    check("imm_imm", imm_out, 8'h42);
    check("imm_addr", addr, 16'h0201);
    check("imm_pc", pc_out, 16'h0202);

    // ZPG_X with zero-page wrap, ready held, done pulse
    hold_reset();
    mem[16'h0200] = 8'hB5;
    mem[16'h0201] = 8'hF0;
    x_in = 8'h20;
    release_reset();
    wait_ready(lat);
    check("zpgx_lat", lat, 3);
    check("zpgx_addr", addr, 16'h0010);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("zpgx_hold_ready", instruction_ready, 1);
    end
    check("zpgx_hold_addr", addr, 16'h0010);
    check("zpgx_hold_instr", instruction_out, 8'hB5);
    done_pulse();
    check("zpgx_ready_drop", instruction_ready, 0);
    check("zpgx_pc_next", pc_out, 16'h0202);
    @(posedge clk);
    #1;
    check("zpgx_next_fetch_addr", mem_addr, 16'h0202);
    check("zpgx_next_fetch_rd", mem_rd, 1);

    // ABS_X with carry into hi byte
    hold_reset();
    mem[16'h0200] = 8'hBD;
    mem[16'h0201] = 8'hFF;
    mem[16'h0202] = 8'h12;
    x_in = 8'h01;
    release_reset();
    wait_ready(lat);
    check("absx_lat", lat, 4);
    check("absx_addr", addr, 16'h1300);
    check("absx_imm", imm_out, 8'hFF);
    check("absx_pc", pc_out, 16'h0203);

    // ABS_Y wrapping past FFFF
    hold_reset();
    mem[16'h0200] = 8'hB9;
    mem[16'h0201] = 8'hFF;
    mem[16'h0202] = 8'hFF;
    x_in = 8'h00;
    y_in = 8'h02;
    release_reset();
    wait_ready(lat);
    check("absy_lat", lat, 4);
    check("absy_addr", addr, 16'h0001);

    // X_IND with pointer hi wrapping FF -> 00
    hold_reset();
    mem[16'h0200] = 8'hA1;
    mem[16'h0201] = 8'hFE;
    mem[16'h00FF] = 8'h34;
    mem[16'h0000] = 8'h12;
    x_in = 8'h01;
    y_in = 8'h00;
    release_reset();
    wait_ready(lat);
    check("xind_lat", lat, 5);
    check("xind_addr", addr, 16'h1234);
    check("xind_instr", instruction_out, 8'hA1);

    // IND_Y; X must not contribute
    hold_reset();
    mem[16'h0200] = 8'hB1;
    mem[16'h0201] = 8'h10;
    mem[16'h0010] = 8'hF0;
    mem[16'h0011] = 8'h20;
    x_in = 8'h55;
    y_in = 8'h20;
    release_reset();
    wait_ready(lat);
    check("indy_lat", lat, 5);
    check("indy_addr", addr, 16'h2110);
    check("indy_pc", pc_out, 16'h0202);

    // PC load in READY; pc_load held outside READY is ignored
    mem[16'h8000] = 8'hA5;
    mem[16'h8001] = 8'h77;
    pc_load = 1'b1;
    pc_in   = 16'h8000;
    done_pulse();
    check("load_pc", pc_out, 16'h8000);
    check("load_ready_drop", instruction_ready, 0);
    pc_in = 16'h4000;
    @(posedge clk);
    #1;
    check("load_fetch_addr", mem_addr, 16'h8000);
    check("load_fetch_rd", mem_rd, 1);
    check("load_ignored_pc", pc_out, 16'h8001);
    wait_ready(lat);
    check("load_zpg_lat", lat, 2);
    check("load_zpg_addr", addr, 16'h0077);
    check("load_zpg_pc", pc_out, 16'h8002);
    pc_load = 1'b0;

    // Async reset in OPH of an ABS fetch, then clean refetch
    hold_reset();
    mem[16'h0200] = 8'hBD;
    mem[16'h0201] = 8'h34;
    mem[16'h0202] = 8'h12;
    x_in = 8'h00;
    release_reset();
    repeat (3) @(posedge clk);
    #1;
    check("oph_mem_rd", mem_rd, 1);
    check("oph_ready", instruction_ready, 0);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_mem_addr", mem_addr, 16'h0000);
    check("midrst_mem_rd", mem_rd, 0);
    check("midrst_instr", instruction_out, 8'h00);
    check("midrst_imm", imm_out, 8'h00);
    check("midrst_addr", addr, 16'h0000);
    check("midrst_pc", pc_out, 16'h0200);
    release_reset();
    wait_ready(lat);
    check("refetch_lat", lat, 4);
    check("refetch_addr", addr, 16'h1234);
    check("refetch_instr", instruction_out, 8'hBD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
